// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B, one bit per clock, LSB first,
// using a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] d_sr_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic             d_s;
  logic             bo_s;
  logic             last_s;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic diff;
    logic bout;
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, diff};
  endfunction

  // Next-state decode and the combinational subtractor cell.
  always_comb begin
    state_next_s = state_r;
    {bo_s, d_s}  = full_sub(a_sr_r[0], b_sr_r[0], br_r);
    last_s       = (cnt_r == LAST);
    case (state_r)
      IDLE: begin
        if (start) state_next_s = SHIFT;
        else       state_next_s = IDLE;
      end
      SHIFT: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = SHIFT;
      end
      DONE: begin
        if (start) state_next_s = SHIFT;
        else       state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs; busy/done follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      d_sr_r  <= '0;
      br_r    <= 1'b0;
      cnt_r   <= '0;
      Diff    <= '0;
      Borrow  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s == SHIFT);
      done    <= (state_next_s == DONE);
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            a_sr_r <= A;
            b_sr_r <= B;
            br_r   <= 1'b0;
            cnt_r  <= '0;
          end
        end
        SHIFT: begin
          a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
          d_sr_r <= {d_s, d_sr_r[WIDTH-1:1]};
          br_r   <= bo_s;
          cnt_r  <= cnt_r + CW'(1);
          // Publish on the final bit so the result includes it.
          if (last_s) begin
            Diff   <= {d_s, d_sr_r[WIDTH-1:1]};
            Borrow <= bo_s;
          end
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 4).
module tb_serial_subtractor;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Diff;
  logic       Borrow;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;
  int prev_d;
  int prev_b;
  int n_done;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .A      (A),
    .B      (B),
    .Diff   (Diff),
    .Borrow (Borrow),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Single operation; A/B are scrambled during SHIFT to show they are ignored.
  task automatic run_op(input int a, input int b, input int exp_d, input int exp_b);
    A     = 4'(a);
    B     = 4'(b);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    A     = ~4'(a);
    B     = ~4'(b);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("busy_%0d_%0d_k%0d", a, b, k), int'(busy), 1);
      check($sformatf("done_lo_%0d_%0d_k%0d", a, b, k), int'(done), 0);
      check($sformatf("diff_hold_%0d_%0d_k%0d", a, b, k), int'(Diff), prev_d);
      check($sformatf("borrow_hold_%0d_%0d_k%0d", a, b, k), int'(Borrow), prev_b);
      next_cycle();
    end
    check($sformatf("done_%0d_%0d", a, b), int'(done), 1);
    check($sformatf("busy_end_%0d_%0d", a, b), int'(busy), 0);
    check($sformatf("diff_%0d_%0d", a, b), int'(Diff), exp_d);
    check($sformatf("borrow_%0d_%0d", a, b), int'(Borrow), exp_b);
    next_cycle();
    check($sformatf("done_once_%0d_%0d", a, b), int'(done), 0);
    check($sformatf("busy_idle_%0d_%0d", a, b), int'(busy), 0);
    check($sformatf("diff_kept_%0d_%0d", a, b), int'(Diff), exp_d);
    prev_d = exp_d;
    prev_b = exp_b;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    prev_d   = 0;
    prev_b   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    A        = 4'd0;
    B        = 4'd0;
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Reset state held through idle cycles.
    for (int i = 0; i < 3; i++) begin
      check("rst_diff", int'(Diff), 0);
      check("rst_borrow", int'(Borrow), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      next_cycle();
    end

    run_op(9, 3, 6, 0);
    run_op(3, 9, 10, 1);
    run_op(0, 15, 1, 1);
    run_op(7, 7, 0, 0);

    // Back-to-back with start held high.
    n_done = 0;
    A     = 4'd15;
    B     = 4'd1;
    start = 1'b1;
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      if (done) n_done++;
      if (k == 4) begin
        check("b2b_done1", int'(done), 1);
        check("b2b_diff1", int'(Diff), 14);
        check("b2b_borrow1", int'(Borrow), 0);
        A = 4'd2;
        B = 4'd5;
      end else if (k == 9) begin
        check("b2b_done2", int'(done), 1);
        check("b2b_diff2", int'(Diff), 13);
        check("b2b_borrow2", int'(Borrow), 1);
        start = 1'b0;
      end else begin
        check($sformatf("b2b_busy_k%0d", k), int'(busy), 1);
      end
      next_cycle();
    end
    check("b2b_pulses", n_done, 2);
    check("b2b_idle_busy", int'(busy), 0);
    check("b2b_idle_done", int'(done), 0);
    check("b2b_held", int'(Diff), 13);
    prev_d = 13;
    prev_b = 1;

    // Reset during the second SHIFT cycle abandons the operation.
    A     = 4'd12;
    B     = 4'd4;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("mid_rst_diff", int'(Diff), 0);
    check("mid_rst_borrow", int'(Borrow), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) n_done++;
      next_cycle();
    end
    check("mid_rst_quiet", n_done, 0);
    prev_d = 0;
    prev_b = 0;
    run_op(5, 2, 3, 0);

    // Exhaustive sweep against the arithmetic reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, (a - b) & 15, (a < b) ? 1 : 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
